// File: rtl/ai_pkg.sv
// rtl/ai_pkg.sv - state encoding and coordinate types shared by the AI scheduler and chase unit
package ai_pkg;

  localparam int COORD_W = 9;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_READ,
    ST_LOAD,
    ST_WRITE,
    ST_DONE,
    ST_SKIP
  } ai_state_t;

endpackage

// File: rtl/ai_frame_divider.sv
// rtl/ai_frame_divider.sv - counts accepted frame ticks modulo MOVE_PERIOD; fires on the tick seen at count 0
module ai_frame_divider #(
  parameter int MOVE_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic fire
);

  localparam int CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = (cnt_q == CNT_W'(MOVE_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  // The pass is keyed on the pre-increment value so the first tick after reset fires.
  assign fire = tick && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/enemy_ai_scheduler.sv
// rtl/enemy_ai_scheduler.sv - walks the enemy position buffer once per AI pass (read, chase, write back)
// Optional AI_ALIVE_MASK_EN adds ENEMY_ALIVE and a one-cycle SKIP for dead slots.
module enemy_ai_scheduler
  import ai_pkg::*;
#(
  parameter int NUM_ENEMIES = 8,
  parameter int MOVE_PERIOD = 4
) (
  input  logic                           CLOCK_50,
  input  logic                           RESET_H,
  input  logic                           FRAME_START,
  output logic                           GET_PLAYER_POS,
  output logic                           RUN_AI,
  output logic [$clog2(NUM_ENEMIES)-1:0] BUF_ADDR,
  output logic                           BUF_RD,
  output logic                           BUF_WR,
  input  logic [COORD_W-1:0]             BUF_RDATA_X,
  input  logic [COORD_W-1:0]             BUF_RDATA_Y,
  output logic [COORD_W-1:0]             TARGET_X,
  output logic [COORD_W-1:0]             TARGET_Y,
  input  logic [COORD_W-1:0]             NEW_ENEMY_X,
  input  logic [COORD_W-1:0]             NEW_ENEMY_Y,
  output logic [COORD_W-1:0]             BUF_WDATA_X,
  output logic [COORD_W-1:0]             BUF_WDATA_Y,
  output logic                           BUSY,
  output logic                           DONE,
`ifdef AI_ALIVE_MASK_EN
  input  logic [NUM_ENEMIES-1:0]         ENEMY_ALIVE,
`endif
  output logic                           MISSED
);

  localparam int SLOT_W = $clog2(NUM_ENEMIES);

  ai_state_t         state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  coord_t            target_x_q, target_x_d;
  coord_t            target_y_q, target_y_d;
  logic              missed_q, missed_d;

  logic              frame_tick;
  logic              pass_fire;
  logic              last_slot;
  logic [SLOT_W-1:0] slot_inc;
  logic              alive_first;
  logic              alive_next;

  // Frames arriving mid-pass are dropped and must not shift the AI cadence.
  assign frame_tick = FRAME_START && (state_q == ST_IDLE);

  ai_frame_divider #(
    .MOVE_PERIOD(MOVE_PERIOD)
  ) u_frame_divider (
    .clk (CLOCK_50),
    .rst (RESET_H),
    .tick(frame_tick),
    .fire(pass_fire)
  );

  assign last_slot = (slot_q == SLOT_W'(NUM_ENEMIES - 1));
  assign slot_inc  = slot_q + 1'b1;

`ifdef AI_ALIVE_MASK_EN
  assign alive_first = ENEMY_ALIVE[0];
  assign alive_next  = ENEMY_ALIVE[slot_inc];
`else
  assign alive_first = 1'b1;
  assign alive_next  = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    target_x_d = target_x_q;
    target_y_d = target_y_q;
    missed_d   = FRAME_START && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (pass_fire) begin
          state_d = ST_CAPTURE;
          slot_d  = '0;
        end
      end
      ST_CAPTURE: state_d = alive_first ? ST_READ : ST_SKIP;
      ST_READ:    state_d = ST_LOAD;
      ST_LOAD: begin
        target_x_d = BUF_RDATA_X;
        target_y_d = BUF_RDATA_Y;
        state_d    = ST_WRITE;
      end
      ST_WRITE, ST_SKIP: begin
        if (last_slot) begin
          state_d = ST_DONE;
        end else begin
          slot_d  = slot_inc;
          state_d = alive_next ? ST_READ : ST_SKIP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET_H) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      target_x_q <= '0;
      target_y_q <= '0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      target_x_q <= target_x_d;
      target_y_q <= target_y_d;
      missed_q   <= missed_d;
    end
  end

  assign GET_PLAYER_POS = (state_q == ST_CAPTURE);
  assign BUF_RD         = (state_q == ST_READ);
  assign BUF_WR         = (state_q == ST_WRITE);
  assign RUN_AI         = (state_q == ST_WRITE);
  assign BUF_ADDR       = slot_q;
  assign TARGET_X       = target_x_q;
  assign TARGET_Y       = target_y_q;
  assign BUF_WDATA_X    = NEW_ENEMY_X;
  assign BUF_WDATA_Y    = NEW_ENEMY_Y;
  assign BUSY           = (state_q != ST_IDLE);
  assign DONE           = (state_q == ST_DONE);
  assign MISSED         = missed_q;

endmodule

// File: tb/tb_enemy_ai_scheduler.sv
// tb/tb_enemy_ai_scheduler.sv - scoreboard bench for enemy_ai_scheduler with a pass-level reference model
module tb_enemy_ai_scheduler;
  import ai_pkg::*;

  localparam int N  = 8;
  localparam int MP = 4;
  localparam int AW = $clog2(N);
  localparam coord_t PX = 9'd300;
  localparam coord_t PY = 9'd60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic gpp, run_ai, rd, wr, busy, done, missed;
  logic [AW-1:0] addr;
  coord_t rdata_x, rdata_y, tgt_x, tgt_y, new_x, new_y, wd_x, wd_y;
  logic [N-1:0] alive;

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  enemy_ai_scheduler #(.NUM_ENEMIES(N), .MOVE_PERIOD(MP)) dut (
    .CLOCK_50(clk), .RESET_H(rst), .FRAME_START(frame_start),
    .GET_PLAYER_POS(gpp), .RUN_AI(run_ai), .BUF_ADDR(addr), .BUF_RD(rd), .BUF_WR(wr),
    .BUF_RDATA_X(rdata_x), .BUF_RDATA_Y(rdata_y), .TARGET_X(tgt_x), .TARGET_Y(tgt_y),
    .NEW_ENEMY_X(new_x), .NEW_ENEMY_Y(new_y), .BUF_WDATA_X(wd_x), .BUF_WDATA_Y(wd_y),
    .BUSY(busy), .DONE(done),
`ifdef AI_ALIVE_MASK_EN
    .ENEMY_ALIVE(alive),
`endif
    .MISSED(missed)
  );

  // Chase unit: one step toward a fixed player position on each axis.
  function automatic coord_t chase(input coord_t v, input coord_t p);
    if (v < p) return v + 1'b1;
    else if (v > p) return v - 1'b1;
    else return v;
  endfunction

  assign new_x = chase(tgt_x, PX);
  assign new_y = chase(tgt_y, PY);

  // Position buffer: synchronous read, one-cycle latency.
  coord_t mem_x[N], mem_y[N], init_x[N], init_y[N];
  logic mem_load = 1'b1;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < N; i++) begin
        mem_x[i] <= init_x[i];
        mem_y[i] <= init_y[i];
      end
    end else begin
      if (rd) begin
        rdata_x <= mem_x[addr];
        rdata_y <= mem_y[addr];
      end
      if (wr) begin
        mem_x[addr] <= wd_x;
        mem_y[addr] <= wd_y;
      end
    end
  end

  typedef struct {
    int     cyc;
    int     slot;
    coord_t tx, ty, wx, wy;
  } wr_exp_t;

  wr_exp_t wr_q[$];
  int done_q[$];
  int miss_q[$];
  int gpp_q[$];

  coord_t model_x[N], model_y[N];
  int fcnt = 0;
  bit m_active = 1'b0;
  int m_lo = 0, m_hi = 0;
  bit mon_en = 1'b0;
  int gpp_seen = 0;

  int n_chk = 0, n_fail = 0;

  function automatic void chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
    end
  endfunction

  // Reference pass: k is the sampling edge; observed cycle c is the state after edge c.
  task automatic start_pass(input int k);
    int c;
    wr_exp_t w;
    gpp_q.push_back(k);
    c = k + 1;
    for (int i = 0; i < N; i++) begin
      if (alive[i]) begin
        w.cyc = c + 2;
        w.slot = i;
        w.tx = model_x[i];
        w.ty = model_y[i];
        w.wx = chase(model_x[i], PX);
        w.wy = chase(model_y[i], PY);
        model_x[i] = w.wx;
        model_y[i] = w.wy;
        wr_q.push_back(w);
        c += 3;
      end else begin
        c += 1;
      end
    end
    done_q.push_back(c);
    m_active = 1'b1;
    m_lo = k;
    m_hi = c;
  endtask

  task automatic step(input bit fs, input bit rs);
    int e;
    @(negedge clk);
    #1;
    e = cyc + 1;
    if (rs) begin
      while (wr_q.size() != 0 && wr_q[wr_q.size()-1].cyc >= e) begin
        model_x[wr_q[wr_q.size()-1].slot] = wr_q[wr_q.size()-1].tx;
        model_y[wr_q[wr_q.size()-1].slot] = wr_q[wr_q.size()-1].ty;
        wr_q.delete(wr_q.size() - 1);
      end
      while (done_q.size() != 0 && done_q[done_q.size()-1] >= e) done_q.delete(done_q.size() - 1);
      while (miss_q.size() != 0 && miss_q[miss_q.size()-1] >= e) miss_q.delete(miss_q.size() - 1);
      while (gpp_q.size() != 0 && gpp_q[gpp_q.size()-1] >= e) gpp_q.delete(gpp_q.size() - 1);
      fcnt = 0;
      m_active = 1'b0;
    end else if (fs) begin
      if (m_active && e <= m_hi + 1) begin
        miss_q.push_back(e);
      end else begin
        if (fcnt == 0) start_pass(e);
        fcnt = (fcnt + 1) % MP;
      end
    end
    frame_start = fs;
    rst = rs;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", busy, int'(m_active && cyc >= m_lo && cyc <= m_hi));
      chk("rd_wr_exclusive", int'(rd && wr), 0);
      while (wr_q.size() != 0 && wr_q[0].cyc < cyc) begin
        chk("wr_missing", cyc, wr_q[0].cyc);
        wr_q.delete(0);
      end
      while (done_q.size() != 0 && done_q[0] < cyc) begin
        chk("done_missing", cyc, done_q[0]);
        done_q.delete(0);
      end
      while (miss_q.size() != 0 && miss_q[0] < cyc) begin
        chk("missed_missing", cyc, miss_q[0]);
        miss_q.delete(0);
      end
      while (gpp_q.size() != 0 && gpp_q[0] < cyc) begin
        chk("gpp_missing", cyc, gpp_q[0]);
        gpp_q.delete(0);
      end
      if (rd) begin
        chk("rd_pending", int'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          chk("rd_cycle", cyc + 2, wr_q[0].cyc);
          chk("rd_addr", addr, wr_q[0].slot);
        end
      end
      if (wr) begin
        chk("wr_pending", int'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          chk("wr_cycle", cyc, wr_q[0].cyc);
          chk("wr_addr", addr, wr_q[0].slot);
          chk("wr_target_x", tgt_x, wr_q[0].tx);
          chk("wr_target_y", tgt_y, wr_q[0].ty);
          chk("wr_wdata_x", wd_x, wr_q[0].wx);
          chk("wr_wdata_y", wd_y, wr_q[0].wy);
          chk("wr_run_ai", run_ai, 1);
          wr_q.delete(0);
        end
      end
      if (gpp) begin
        gpp_seen++;
        chk("gpp_pending", int'(gpp_q.size() != 0), 1);
        if (gpp_q.size() != 0) begin
          chk("gpp_cycle", cyc, gpp_q[0]);
          chk("gpp_slot0", addr, 0);
          gpp_q.delete(0);
        end
      end
      if (done) begin
        chk("done_pending", int'(done_q.size() != 0), 1);
        if (done_q.size() != 0) begin
          chk("done_cycle", cyc, done_q[0]);
          done_q.delete(0);
        end
      end
      if (missed) begin
        chk("missed_pending", int'(miss_q.size() != 0), 1);
        if (miss_q.size() != 0) begin
          chk("missed_cycle", cyc, miss_q[0]);
          miss_q.delete(0);
        end
      end
    end
  end

  initial begin
    int k, g0;
`ifdef AI_ALIVE_MASK_EN
    alive = 8'b0000_0101;
`else
    alive = '1;
`endif
    for (int i = 0; i < N; i++) begin
      init_x[i] = coord_t'($urandom_range(0, 511));
      init_y[i] = coord_t'($urandom_range(0, 511));
    end
    init_x[3] = 9'd50;
    init_y[3] = 9'd60;
    for (int i = 0; i < N; i++) begin
      model_x[i] = init_x[i];
      model_y[i] = init_y[i];
    end

    repeat (3) step(1'b0, 1'b1);
    mem_load = 1'b0;
    step(1'b0, 1'b0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_missed", missed, 0);
    chk("rst_gpp", gpp, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wr", wr, 0);
    chk("rst_run_ai", run_ai, 0);
    chk("rst_addr", addr, 0);
    chk("rst_target_x", tgt_x, 0);
    chk("rst_target_y", tgt_y, 0);
    mon_en = 1'b1;

    // Eight frames spaced 100 cycles: with MOVE_PERIOD 4 only ticks 1 and 5 run a pass.
    g0 = gpp_seen;
    for (int t = 0; t < 8; t++) begin
      step(1'b1, 1'b0);
      repeat (99) step(1'b0, 1'b0);
    end
    chk("passes_in_8_frames", gpp_seen - g0, 2);

    // Frames during a pass (5 cycles in, and in the DONE cycle) are dropped.
    step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    while (cyc < m_hi - 1) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    while (fcnt != 0) begin
      step(1'b1, 1'b0);
      repeat (40) step(1'b0, 1'b0);
    end

    // Reset right after the slot 2 write, then a fresh pass.
    step(1'b1, 1'b0);
    k = cyc + 1;
    while (cyc < k + 8) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("busy_after_reset", busy, 0);
    repeat (5) step(1'b0, 1'b0);
    g0 = gpp_seen;
    step(1'b1, 1'b0);
    repeat (40) step(1'b0, 1'b0);
    chk("pass_after_reset", gpp_seen - g0, 1);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 399) == 0);
    end
    repeat (60) step(1'b0, 1'b0);

    chk("wr_queue_drained", wr_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    chk("missed_queue_drained", miss_q.size(), 0);
    chk("gpp_queue_drained", gpp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
